// File: rtl/ov7670_capture444.sv
// OV7670 RGB444 capture: pairs camera bytes into 12-bit pixels and writes them
// in raster order to a frame buffer. Ports: clk25/reset, capture_en, cam_* in; frame_* and status out.
module ov7670_capture444 #(
  parameter int H_PIX  = 320,
  parameter int V_PIX  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk25,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              frame_we,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [15:0]       frame_wdata,
  output logic              frame_done,
  output logic [7:0]        line_count,
  output logic              err_overflow,
  output logic              err_line
);

  localparam logic [ADDR_W:0]   TOTAL  = (ADDR_W+1)'(H_PIX * V_PIX);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(H_PIX * V_PIX - 1);
  localparam logic [11:0]       LINE_B = 12'(2 * H_PIX);

  typedef enum logic [2:0] {
    WAIT_VS,
    VS_HIGH,
    ARMED,
    BYTE_HI,
    BYTE_LO,
    END_FRAME
  } state_t;

  state_t            state_q;
  logic              s1_pclk_q, s2_pclk_q, s3_pclk_q;
  logic              s1_vs_q, s2_vs_q;
  logic              s1_href_q, s2_href_q;
  logic [7:0]        s1_data_q, s2_data_q;
  logic              cap_q;
  logic [3:0]        hi_q;
  logic [11:0]       byte_cnt_q;
  logic [7:0]        line_cnt_q;
  logic [ADDR_W:0]   pix_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [15:0]       wdata_q;
  logic              done_q;
  logic [7:0]        lcount_q;
  logic              err_ov_q;
  logic              err_ln_q;

  logic        pe;
  logic [11:0] byte_cnt_d;
  logic [7:0]  line_cnt_d;
  logic        line_bad;

  assign pe = s2_pclk_q & ~s3_pclk_q;

  // Saturating counters so a runaway line or frame cannot wrap.
  assign byte_cnt_d = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 12'd1;
  assign line_cnt_d = (&line_cnt_q) ? line_cnt_q : line_cnt_q + 8'd1;
  assign line_bad   = byte_cnt_q != LINE_B;

  always_ff @(posedge clk25) begin
    if (reset) begin
      state_q    <= WAIT_VS;
      s1_pclk_q  <= 1'b0;
      s2_pclk_q  <= 1'b0;
      s3_pclk_q  <= 1'b0;
      s1_vs_q    <= 1'b0;
      s2_vs_q    <= 1'b0;
      s1_href_q  <= 1'b0;
      s2_href_q  <= 1'b0;
      s1_data_q  <= '0;
      s2_data_q  <= '0;
      cap_q      <= 1'b0;
      hi_q       <= '0;
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      pix_cnt_q  <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      lcount_q   <= '0;
      err_ov_q   <= 1'b0;
      err_ln_q   <= 1'b0;
    end else begin
      s1_pclk_q <= cam_pclk;
      s2_pclk_q <= s1_pclk_q;
      s3_pclk_q <= s2_pclk_q;
      s1_vs_q   <= cam_vsync;
      s2_vs_q   <= s1_vs_q;
      s1_href_q <= cam_href;
      s2_href_q <= s1_href_q;
      s1_data_q <= cam_data;
      s2_data_q <= s1_data_q;
      we_q      <= 1'b0;
      done_q    <= 1'b0;

      // Address advances only after a real write; it parks on the last
      // location while pix_cnt_q keeps tracking overflow.
      if (we_q) begin
        pix_cnt_q <= pix_cnt_q + 1'b1;
        if (addr_q != LAST_A) addr_q <= addr_q + 1'b1;
      end

      unique case (state_q)
        WAIT_VS: begin
          if (pe && s2_vs_q) state_q <= VS_HIGH;
        end
        VS_HIGH: begin
          if (pe && !s2_vs_q) begin
            addr_q     <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            err_ov_q   <= 1'b0;
            err_ln_q   <= 1'b0;
            cap_q      <= capture_en;
            state_q    <= ARMED;
          end
        end
        ARMED: begin
          if (pe) begin
            if (s2_vs_q) begin
              state_q <= END_FRAME;
            end else if (s2_href_q) begin
              hi_q       <= s2_data_q[3:0];
              byte_cnt_q <= 12'd1;
              state_q    <= BYTE_HI;
            end
          end
        end
        BYTE_HI: begin
          if (pe) begin
            if (s2_href_q) begin
              byte_cnt_q <= byte_cnt_d;
              if (cap_q) begin
                if (pix_cnt_q < TOTAL) begin
                  we_q    <= 1'b1;
                  wdata_q <= {4'b0, hi_q, s2_data_q};
                end else begin
                  err_ov_q <= 1'b1;
                end
              end
              state_q <= s2_vs_q ? END_FRAME : BYTE_LO;
            end else begin
              // Odd-length line: the dangling high byte is dropped.
              line_cnt_q <= line_cnt_d;
              if (line_bad) err_ln_q <= 1'b1;
              state_q <= s2_vs_q ? END_FRAME : ARMED;
            end
          end
        end
        BYTE_LO: begin
          if (pe) begin
            if (s2_href_q) begin
              byte_cnt_q <= byte_cnt_d;
              hi_q       <= s2_data_q[3:0];
              state_q    <= s2_vs_q ? END_FRAME : BYTE_HI;
            end else begin
              line_cnt_q <= line_cnt_d;
              if (line_bad) err_ln_q <= 1'b1;
              state_q <= s2_vs_q ? END_FRAME : ARMED;
            end
          end
        end
        END_FRAME: begin
          done_q   <= 1'b1;
          lcount_q <= line_cnt_q;
          state_q  <= VS_HIGH;
        end
        default: state_q <= WAIT_VS;
      endcase
    end
  end

  assign frame_we     = we_q;
  assign frame_addr   = addr_q;
  assign frame_wdata  = wdata_q;
  assign frame_done   = done_q;
  assign line_count   = lcount_q;
  assign err_overflow = err_ov_q;
  assign err_line     = err_ln_q;

endmodule

// File: tb/tb_ov7670_capture444.sv
// Directed bench for ov7670_capture444 on a reduced 4x3 frame.
// Drives camera bytes at clk/4 and checks writes, frame status and latency.
module tb_ov7670_capture444;

  localparam int H = 4;
  localparam int V = 3;
  localparam int LASTA = H * V - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        capture_en = 1'b1;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = '0;
  logic        frame_we;
  logic [16:0] frame_addr;
  logic [15:0] frame_wdata;
  logic        frame_done;
  logic [7:0]  line_count;
  logic        err_overflow;
  logic        err_line;

  ov7670_capture444 #(.H_PIX(H), .V_PIX(V), .ADDR_W(17)) dut (
    .clk25       (clk),
    .reset       (reset),
    .capture_en  (capture_en),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .frame_we    (frame_we),
    .frame_addr  (frame_addr),
    .frame_wdata (frame_wdata),
    .frame_done  (frame_done),
    .line_count  (line_count),
    .err_overflow(err_overflow),
    .err_line    (err_line)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int first_addr = -1;
  int last_addr = -1;
  int bad_data = 0;
  int lat_err = 0;
  int step_err = 0;
  logic        prev_we = 1'b0;
  logic [16:0] prev_addr = '0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_we) begin
      we_cnt++;
      last_addr = int'(frame_addr);
      if (we_cnt == 1) first_addr = int'(frame_addr);
      if (frame_wdata != 16'h0ABC) bad_data++;
      if (cyc != rise_cyc + 2) lat_err++;
    end
    if (prev_we && int'(frame_addr) !=
        ((int'(prev_addr) == LASTA) ? LASTA : int'(prev_addr) + 1))
      step_err++;
    if (frame_done) done_cnt++;
    prev_we = frame_we;
    prev_addr = frame_addr;
  end

  task automatic pbyte(input logic [7:0] d, input logic h, input logic v);
    @(negedge clk);
    cam_data = d; cam_href = h; cam_vsync = v; cam_pclk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cam_pclk = 1'b1;
    rise_cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++)
      pbyte((i % 2) ? 8'hBC : 8'h0A, 1'b1, 1'b0);
    pbyte(8'h00, 1'b0, 1'b0);
    pbyte(8'h00, 1'b0, 1'b0);
  endtask

  task automatic vs_hi();
    pbyte(8'h00, 1'b0, 1'b1);
    pbyte(8'h00, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic vs_lo();
    pbyte(8'h00, 1'b0, 1'b0);
    pbyte(8'h00, 1'b0, 1'b0);
  endtask

  task automatic clr();
    @(negedge clk);
    we_cnt = 0; done_cnt = 0; first_addr = -1; last_addr = -1;
    bad_data = 0; lat_err = 0; step_err = 0;
  endtask

  task automatic frame_chk(input string t, input int we, input int la,
                           input int lc, input int ov, input int el);
    chk({t, "_we"}, we_cnt, we);
    chk({t, "_last"}, last_addr, la);
    chk({t, "_done"}, done_cnt, 1);
    chk({t, "_lines"}, int'(line_count), lc);
    chk({t, "_ov"}, int'(err_overflow), ov);
    chk({t, "_eline"}, int'(err_line), el);
    chk({t, "_step"}, step_err, 0);
    chk({t, "_data"}, bad_data, 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_we", int'(frame_we), 0);
    chk("rst_addr", int'(frame_addr), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_lc", int'(line_count), 0);
    chk("rst_err", int'({err_overflow, err_line}), 0);

    // Two clean frames
    vs_hi();
    for (int f = 0; f < 2; f++) begin
      clr();
      vs_lo();
      repeat (V) line(2 * H);
      vs_hi();
      frame_chk("clean", H * V, LASTA, V, 0, 0);
      chk("clean_first", first_addr, 0);
      chk("latency", lat_err, 0);
    end

    // Long middle line: line error plus overflow
    clr();
    vs_lo();
    line(8); line(10); line(8);
    vs_hi();
    frame_chk("long", H * V, LASTA, 3, 1, 1);

    // Extra line: overflow only
    clr();
    vs_lo();
    repeat (V + 1) line(2 * H);
    vs_hi();
    frame_chk("extra", H * V, LASTA, 4, 1, 0);

    // Odd line drops the dangling byte, addresses stay contiguous
    clr();
    vs_lo();
    line(8); line(7); line(8);
    vs_hi();
    frame_chk("odd", 11, 10, 3, 0, 1);

    // Capture disabled at frame start; later enable is ignored
    clr();
    capture_en = 1'b0;
    vs_lo();
    capture_en = 1'b1;
    repeat (V) line(2 * H);
    vs_hi();
    chk("dis_we", we_cnt, 0);
    chk("dis_done", done_cnt, 1);
    chk("dis_lines", int'(line_count), V);
    clr();
    vs_lo();
    repeat (V) line(2 * H);
    vs_hi();
    frame_chk("reen", H * V, LASTA, V, 0, 0);

    // Reset mid-frame discards the partial frame
    clr();
    vs_lo();
    line(8);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_addr", int'(frame_addr), 0);
    chk("mrst_lc", int'(line_count), 0);
    chk("mrst_err", int'({err_overflow, err_line}), 0);
    clr();
    line(8); line(8);
    vs_hi();
    chk("mrst_we", we_cnt, 0);
    chk("mrst_done", done_cnt, 0);
    clr();
    vs_lo();
    repeat (V) line(2 * H);
    vs_hi();
    frame_chk("post", H * V, LASTA, V, 0, 0);
    chk("post_first", first_addr, 0);
    chk("post_lat", lat_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
